// File: rtl/count_monitor_pkg.sv
// Shared types and the reference next-count function for count_monitor and count_model.
package count_monitor_pkg;

  typedef enum logic {SYNC, TRACK} state_t;

  localparam int MAX_WIDTH = 32;

  // Values arrive zero-extended to MAX_WIDTH; 'width' gives the counter's real width.
  // A mod_value of 0 makes 'last' all ones in width, i.e. a modulus of 2^width.
  function automatic logic [MAX_WIDTH-1:0] next_count(
    input logic                 load,
    input logic [MAX_WIDTH-1:0] load_value,
    input logic [MAX_WIDTH-1:0] mod_value,
    input logic [MAX_WIDTH-1:0] count,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] last;
    if (width >= MAX_WIDTH) mask = '1;
    else mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    last = (mod_value - MAX_WIDTH'(1)) & mask;
    if (load) next_count = load_value & mask;
    else if ((count & mask) == last) next_count = '0;
    else next_count = (count + MAX_WIDTH'(1)) & mask;
  endfunction

endpackage

// File: rtl/count_monitor_model.sv
// Combinational reference predictor for the loadable modulo counter (WIDTH <= 32).
module count_model
  import count_monitor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic [WIDTH-1:0] mod_value_i,
  input  logic [WIDTH-1:0] count_i,
  output logic [WIDTH-1:0] next_o
);

  assign next_o = WIDTH'(next_count(load_i, MAX_WIDTH'(load_value_i), MAX_WIDTH'(mod_value_i),
                                    MAX_WIDTH'(count_i), WIDTH));

endmodule

// File: rtl/count_monitor.sv
// Passive sequence checker for the loadable modulo counter.
// Define COUNT_MONITOR_RANGE_CHECK_EN to enable the sticky count >= mod_value check.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  input  logic [WIDTH-1:0]     mod_value,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap,
  output logic                 range_err
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d, modelNext;
  logic                 wrapArmed_q, wrapArmed_d;
  logic                 err_q, err_d;
  logic                 errFlag_q, errFlag_d;
  logic [ERR_CNT_W-1:0] errCount_q, errCount_d;
  logic                 wrap_q, wrap_d;
  logic                 mismatch;

  count_model #(.WIDTH(WIDTH)) u_model (
    .load_i       (load),
    .load_value_i (load_value),
    .mod_value_i  (mod_value),
    .count_i      (count),
    .next_o       (modelNext)
  );

  always_comb begin
    state_d     = TRACK;
    exp_d       = modelNext;
    wrapArmed_d = ~load & (count == mod_value - WIDTH'(1));
    mismatch    = (state_q == TRACK) && (count != exp_q);
    err_d       = mismatch;
    errFlag_d   = mismatch | (errFlag_q & ~clr_err);
    errCount_d  = errCount_q;
    // A mismatch on the same edge as clr_err leaves a fresh count of one.
    if (mismatch) begin
      if (clr_err) errCount_d = ERR_CNT_W'(1);
      else if (errCount_q != '1) errCount_d = errCount_q + ERR_CNT_W'(1);
    end else if (clr_err) begin
      errCount_d = '0;
    end
    wrap_d = (state_q == TRACK) && !mismatch && (count == '0) && wrapArmed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      exp_q       <= '0;
      wrapArmed_q <= 1'b0;
      err_q       <= 1'b0;
      errFlag_q   <= 1'b0;
      errCount_q  <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      wrapArmed_q <= wrapArmed_d;
      err_q       <= err_d;
      errFlag_q   <= errFlag_d;
      errCount_q  <= errCount_d;
      wrap_q      <= wrap_d;
    end
  end

  assign locked    = (state_q == TRACK);
  assign err       = err_q;
  assign err_flag  = errFlag_q;
  assign err_count = errCount_q;
  assign wrap      = wrap_q;

`ifdef COUNT_MONITOR_RANGE_CHECK_EN
  logic rangeErr_q, rangeErr_d;
  logic rangeSkip_q, rangeSkip_d;
  logic rangeViol;

  // An out-of-range software load is legal, so its first sample is exempt.
  always_comb begin
    rangeSkip_d = load & (mod_value != '0) & (load_value >= mod_value);
    rangeViol   = (state_q == TRACK) && (mod_value != '0) && (count >= mod_value) && !rangeSkip_q;
    rangeErr_d  = rangeViol | (rangeErr_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rangeErr_q  <= 1'b0;
      rangeSkip_q <= 1'b0;
    end else begin
      rangeErr_q  <= rangeErr_d;
      rangeSkip_q <= rangeSkip_d;
    end
  end

  assign range_err = rangeErr_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor (WIDTH=8, ERR_CNT_W=2).
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] mod_value;
  logic [7:0] count;
  logic       clr_err;
  logic       locked, err, err_flag, wrap, range_err;
  logic [1:0] err_count;

  int checks = 0;
  int passes = 0;

`ifdef COUNT_MONITOR_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  always #5 clk = ~clk;

  count_monitor #(.WIDTH(8), .ERR_CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .mod_value  (mod_value),
    .count      (count),
    .clr_err    (clr_err),
    .locked     (locked),
    .err        (err),
    .err_flag   (err_flag),
    .err_count  (err_count),
    .wrap       (wrap),
    .range_err  (range_err)
  );

  // Apply one cycle of inputs and return 1 time unit after the sampling edge.
  task automatic drive(input logic l, input logic [7:0] lv, input logic [7:0] md,
                       input logic [7:0] c, input logic cl);
    load = l; load_value = lv; mod_value = md; count = c; clr_err = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd18, 8'd0, 1'b0);
    drive(1'b0, 8'd0, 8'd18, 8'd0, 1'b0);
    rst = 1'b0;
    checks++;
    if ({locked, err, err_flag, err_count, wrap, range_err} !== 7'b0)
      $display("[TB] FAIL reset_outputs: got %b, want 0000000",
               {locked, err, err_flag, err_count, wrap, range_err});
    else passes++;
  endtask

  task automatic test_sequence();
    logic [7:0] seq [15];
    int errSeen = 0;
    int wrapBad = 0;
    for (int i = 0; i < 13; i++) seq[i] = 8'(5 + i);
    seq[13] = 8'd0;
    seq[14] = 8'd1;
    drive(1'b1, 8'd5, 8'd18, 8'd0, 1'b0);
    checks++;
    if (locked !== 1'b1) $display("[TB] FAIL lock_rise: got %b, want 1", locked);
    else passes++;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 8'd0, 8'd18, seq[i], 1'b0);
      if (err !== 1'b0) errSeen++;
      if (wrap !== (seq[i] == 8'd0)) wrapBad++;
    end
    checks++;
    if (errSeen != 0) $display("[TB] FAIL seq_no_err: got %0d err pulses, want 0", errSeen);
    else passes++;
    checks++;
    if (wrapBad != 0) $display("[TB] FAIL seq_wrap: got %0d wrong wrap cycles, want 0", wrapBad);
    else passes++;
    checks++;
    if (err_count !== 2'd0 || locked !== 1'b1)
      $display("[TB] FAIL seq_final: got cnt=%0d locked=%b, want cnt=0 locked=1", err_count, locked);
    else passes++;
  endtask

  task automatic test_resync();
    logic [7:0] seq [4];
    logic       want [4];
    seq = '{8'd7, 8'd8, 8'd10, 8'd11};
    want = '{1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 8'd7, 8'd18, 8'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd0, 8'd18, seq[i], 1'b0);
      checks++;
      if (err !== want[i]) $display("[TB] FAIL resync_err[%0d]: got %b, want %b", i, err, want[i]);
      else passes++;
    end
    checks++;
    if (err_count !== 2'd1 || err_flag !== 1'b1)
      $display("[TB] FAIL resync_flags: got cnt=%0d flag=%b, want cnt=1 flag=1", err_count, err_flag);
    else passes++;
  endtask

  task automatic test_saturate();
    logic [1:0] want;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'd0, 8'd18, 8'd50, 1'b0);
      want = (i == 0) ? 2'd2 : 2'd3;
      checks++;
      if (err !== 1'b1 || err_count !== want)
        $display("[TB] FAIL sat[%0d]: got err=%b cnt=%0d, want err=1 cnt=%0d", i, err, err_count, want);
      else passes++;
    end
    drive(1'b0, 8'd0, 8'd18, 8'd51, 1'b1);
    checks++;
    if (err !== 1'b0 || err_count !== 2'd0 || err_flag !== 1'b0)
      $display("[TB] FAIL clr_alone: got err=%b cnt=%0d flag=%b, want 0 0 0", err, err_count, err_flag);
    else passes++;
  endtask

  task automatic test_clr_collision();
    drive(1'b0, 8'd0, 8'd18, 8'd60, 1'b1);
    checks++;
    if (err !== 1'b1 || err_count !== 2'd1 || err_flag !== 1'b1)
      $display("[TB] FAIL clr_collide: got err=%b cnt=%0d flag=%b, want 1 1 1", err, err_count, err_flag);
    else passes++;
    drive(1'b0, 8'd0, 8'd18, 8'd61, 1'b1);
    checks++;
    if (err_count !== 2'd0 || err_flag !== 1'b0)
      $display("[TB] FAIL clr_after: got cnt=%0d flag=%b, want 0 0", err_count, err_flag);
    else passes++;
  endtask

  task automatic test_mod0_and_reset();
    logic [7:0] seq [3];
    seq = '{8'd254, 8'd255, 8'd0};
    drive(1'b1, 8'd254, 8'd0, 8'd62, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 8'd0, seq[i], 1'b0);
      checks++;
      if (err !== 1'b0 || wrap !== (i == 2))
        $display("[TB] FAIL mod0[%0d]: got err=%b wrap=%b, want err=0 wrap=%b", i, err, wrap, (i == 2));
      else passes++;
    end
    drive(1'b0, 8'd0, 8'd0, 8'd7, 1'b0);
    checks++;
    if (err !== 1'b1 || err_flag !== 1'b1)
      $display("[TB] FAIL mod0_err: got err=%b flag=%b, want 1 1", err, err_flag);
    else passes++;
    rst = 1'b1;
    drive(1'b1, 8'd3, 8'd0, 8'd99, 1'b0);
    rst = 1'b0;
    checks++;
    if ({locked, err, err_flag, err_count, wrap, range_err} !== 7'b0)
      $display("[TB] FAIL mid_reset: got %b, want 0000000",
               {locked, err, err_flag, err_count, wrap, range_err});
    else passes++;
  endtask

  task automatic test_range();
    drive(1'b1, 8'd5, 8'd10, 8'd0, 1'b0);
    for (int c = 5; c < 10; c++) drive(1'b0, 8'd0, 8'd10, 8'(c), 1'b0);
    checks++;
    if (range_err !== 1'b0) $display("[TB] FAIL range_inrange: got %b, want 0", range_err);
    else passes++;
    drive(1'b0, 8'd0, 8'd10, 8'd12, 1'b0);
    checks++;
    if (err !== 1'b1 || range_err !== RC)
      $display("[TB] FAIL range_set: got err=%b range=%b, want err=1 range=%b", err, range_err, RC);
    else passes++;
    drive(1'b1, 8'd2, 8'd10, 8'd13, 1'b0);
    checks++;
    if (range_err !== RC) $display("[TB] FAIL range_sticky: got %b, want %b", range_err, RC);
    else passes++;
    drive(1'b0, 8'd0, 8'd10, 8'd2, 1'b1);
    checks++;
    if (range_err !== 1'b0 || err_count !== 2'd0)
      $display("[TB] FAIL range_clr: got range=%b cnt=%0d, want 0 0", range_err, err_count);
    else passes++;
    drive(1'b1, 8'd12, 8'd10, 8'd3, 1'b0);
    drive(1'b0, 8'd0, 8'd10, 8'd12, 1'b0);
    checks++;
    if (err !== 1'b0 || range_err !== 1'b0)
      $display("[TB] FAIL range_load_skip: got err=%b range=%b, want 0 0", err, range_err);
    else passes++;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_value = '0; mod_value = 8'd18; count = '0; clr_err = 1'b0;
    test_reset();
    test_sequence();
    test_resync();
    test_saturate();
    test_clr_collision();
    test_mod0_and_reset();
    test_range();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
